plot_sequencer: RTL and testbench

//  Top-level plotting controller. Sequences up to FUNC_COUNT expressions:

---
 rtl/plot_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_plot_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sequencer.sv
// Plot sequencer: parses each expression, sweeps x through the evaluator and emits line segments.
// Optional PLOT_SEQUENCER_AXES_EN: draw the two screen axes on channel FUNC_COUNT before function 0.
module plot_sequencer #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FUNC_COUNT        = 4,
  parameter int X_STEP            = 1,
  localparam int XW = $clog2(HOR_ACTIVE_PIXELS),
  localparam int YW = $clog2(VER_ACTIVE_PIXELS),
  localparam int FW = $clog2(FUNC_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ready,
  output logic                  done,
  output logic [FUNC_COUNT-1:0] errors,
  output logic [FW-1:0]         func_index,
  output logic                  parser_start,
  input  logic                  parser_ready,
  input  logic                  parser_error,
  output logic                  eval_start,
  input  logic                  eval_ready,
  output logic [XW-1:0]         eval_x,
  input  logic [YW-1:0]         eval_y,
  input  logic                  eval_y_valid,
  output logic [XW-1:0]         x1,
  output logic [YW-1:0]         y1,
  output logic [XW-1:0]         x2,
  output logic [YW-1:0]         y2,
  output logic                  line_start,
  input  logic                  line_ready,
  output logic [FW-1:0]         line_channel,
  output logic [3:0]            state_dbg
);

  // Handshake (parser, evaluator, line drawer alike): *_start is high for exactly
  // one cycle in *_GO; the following GUARD cycle ignores *_ready; *_WAIT holds
  // until *_ready==1, and the result inputs are sampled on that same edge.
  typedef enum logic [3:0] {
    S_IDLE, S_PARSE_GO, S_PARSE_GUARD, S_PARSE_WAIT,
    S_EVAL_GO, S_EVAL_GUARD, S_EVAL_WAIT,
    S_LINE_GO, S_LINE_GUARD, S_LINE_WAIT,
    S_ADVANCE, S_NEXT_FUNC, S_DRAIN_GUARD, S_DRAIN
  } state_t;

  typedef enum logic [1:0] {D_PARSER, D_EVAL, D_LINE} drain_t;

  localparam logic [XW:0]   X_LAST  = (XW+1)'(HOR_ACTIVE_PIXELS - 1);
  localparam logic [XW:0]   X_INC   = (XW+1)'(X_STEP);
  localparam logic [FW-1:0] F_LAST  = FW'(FUNC_COUNT - 1);

  state_t          state, state_nxt;
  drain_t          drain_sel, drain_nxt;
  logic [XW-1:0]   prev_x;
  logic [YW-1:0]   prev_y;
  logic            prev_valid;
  logic [XW:0]     x_sum;
  logic [XW-1:0]   x_next;

  logic run_init, err_set, x_init, point_take, seg_load, x_step, func_inc;
  logic axis_second, axis_done;

`ifdef PLOT_SEQUENCER_AXES_EN
  logic axis_phase, axis_sel;
`else
  logic axis_phase;
  assign axis_phase = 1'b0;
`endif

  assign state_dbg = state;
  // Sum is one bit wider so a stride past the edge clamps to the last column.
  assign x_sum  = {1'b0, eval_x} + X_INC;
  assign x_next = (x_sum > X_LAST) ? X_LAST[XW-1:0] : x_sum[XW-1:0];

  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_sel;
    ready        = 1'b0;
    done         = 1'b0;
    parser_start = 1'b0;
    eval_start   = 1'b0;
    line_start   = 1'b0;
    run_init     = 1'b0;
    err_set      = 1'b0;
    x_init       = 1'b0;
    point_take   = 1'b0;
    seg_load     = 1'b0;
    x_step       = 1'b0;
    func_inc     = 1'b0;
    axis_second  = 1'b0;
    axis_done    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start && !abort) begin
          run_init = 1'b1;
`ifdef PLOT_SEQUENCER_AXES_EN
          state_nxt = S_LINE_GO;
`else
          state_nxt = S_PARSE_GO;
`endif
        end
      end
      S_PARSE_GO: begin
        parser_start = 1'b1;
        drain_nxt    = D_PARSER;
        state_nxt    = abort ? S_DRAIN_GUARD : S_PARSE_GUARD;
      end
      S_PARSE_GUARD: begin
        drain_nxt = D_PARSER;
        state_nxt = abort ? S_DRAIN : S_PARSE_WAIT;
      end
      S_PARSE_WAIT: begin
        drain_nxt = D_PARSER;
        if (parser_ready) begin
          if (abort) state_nxt = S_IDLE;
          else if (parser_error) begin
            err_set   = 1'b1;
            state_nxt = S_NEXT_FUNC;
          end else begin
            x_init    = 1'b1;
            state_nxt = S_EVAL_GO;
          end
        end else if (abort) state_nxt = S_DRAIN;
      end
      S_EVAL_GO: begin
        eval_start = 1'b1;
        drain_nxt  = D_EVAL;
        state_nxt  = abort ? S_DRAIN_GUARD : S_EVAL_GUARD;
      end
      S_EVAL_GUARD: begin
        drain_nxt = D_EVAL;
        state_nxt = abort ? S_DRAIN : S_EVAL_WAIT;
      end
      S_EVAL_WAIT: begin
        drain_nxt = D_EVAL;
        if (eval_ready) begin
          if (abort) state_nxt = S_IDLE;
          else begin
            point_take = 1'b1;
            seg_load   = prev_valid && eval_y_valid;
            state_nxt  = (prev_valid && eval_y_valid) ? S_LINE_GO : S_ADVANCE;
          end
        end else if (abort) state_nxt = S_DRAIN;
      end
      S_LINE_GO: begin
        line_start = 1'b1;
        drain_nxt  = D_LINE;
        state_nxt  = abort ? S_DRAIN_GUARD : S_LINE_GUARD;
      end
      S_LINE_GUARD: begin
        drain_nxt = D_LINE;
        state_nxt = abort ? S_DRAIN : S_LINE_WAIT;
      end
      S_LINE_WAIT: begin
        drain_nxt = D_LINE;
        if (line_ready) begin
          if (abort) state_nxt = S_IDLE;
          else if (axis_phase) begin
`ifdef PLOT_SEQUENCER_AXES_EN
            if (!axis_sel) begin
              axis_second = 1'b1;
              state_nxt   = S_LINE_GO;
            end else begin
              axis_done = 1'b1;
              state_nxt = S_PARSE_GO;
            end
`endif
          end else state_nxt = S_ADVANCE;
        end else if (abort) state_nxt = S_DRAIN;
      end
      S_ADVANCE: begin
        if (abort) state_nxt = S_IDLE;
        else if ({1'b0, eval_x} == X_LAST) state_nxt = S_NEXT_FUNC;
        else begin
          x_step    = 1'b1;
          state_nxt = S_EVAL_GO;
        end
      end
      S_NEXT_FUNC: begin
        if (abort) state_nxt = S_IDLE;
        else if (func_index == F_LAST) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          func_inc  = 1'b1;
          state_nxt = S_PARSE_GO;
        end
      end
      S_DRAIN_GUARD: state_nxt = S_DRAIN;
      S_DRAIN: begin
        case (drain_sel)
          D_PARSER: if (parser_ready) state_nxt = S_IDLE;
          D_EVAL:   if (eval_ready)   state_nxt = S_IDLE;
          default:  if (line_ready)   state_nxt = S_IDLE;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      drain_sel    <= D_PARSER;
      errors       <= '0;
      func_index   <= '0;
      eval_x       <= '0;
      prev_x       <= '0;
      prev_y       <= '0;
      prev_valid   <= 1'b0;
      x1           <= '0;
      y1           <= '0;
      x2           <= '0;
      y2           <= '0;
      line_channel <= '0;
`ifdef PLOT_SEQUENCER_AXES_EN
      axis_phase   <= 1'b0;
      axis_sel     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      drain_sel <= drain_nxt;
      if (run_init) begin
        errors     <= '0;
        func_index <= '0;
      end
      if (err_set)  errors <= errors | (FUNC_COUNT'(1) << func_index);
      if (func_inc) func_index <= func_index + 1'b1;
      if (x_init) begin
        eval_x     <= '0;
        prev_valid <= 1'b0;
      end
      if (x_step) eval_x <= x_next;
      if (point_take) begin
        prev_x     <= eval_x;
        prev_y     <= eval_y;
        prev_valid <= eval_y_valid;
      end
      if (seg_load) begin
        x1           <= prev_x;
        y1           <= prev_y;
        x2           <= eval_x;
        y2           <= eval_y;
        line_channel <= func_index;
      end
`ifdef PLOT_SEQUENCER_AXES_EN
      // Horizontal axis first, then the vertical one, both on the spare channel.
      if (run_init) begin
        axis_phase   <= 1'b1;
        axis_sel     <= 1'b0;
        x1           <= '0;
        y1           <= YW'(VER_ACTIVE_PIXELS / 2);
        x2           <= XW'(HOR_ACTIVE_PIXELS - 1);
        y2           <= YW'(VER_ACTIVE_PIXELS / 2);
        line_channel <= FW'(FUNC_COUNT);
      end
      if (axis_second) begin
        axis_sel <= 1'b1;
        x1       <= XW'(HOR_ACTIVE_PIXELS / 2);
        y1       <= '0;
        x2       <= XW'(HOR_ACTIVE_PIXELS / 2);
        y2       <= YW'(VER_ACTIVE_PIXELS - 1);
      end
      if (axis_done) axis_phase <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_plot_sequencer.sv
// Bench for plot_sequencer: bench-side parser/evaluator/line responders and an expected-event model.
module tb_plot_sequencer;
  localparam int HOR = 8, VER = 6, FC = 2, STEP = 3;
  localparam int XW = 3, YW = 3, FW = 2;
  localparam int SW = FW + 2*XW + 2*YW;
  localparam int EW = FW + XW;
`ifdef PLOT_SEQUENCER_AXES_EN
  localparam int AXES = 1;
`else
  localparam int AXES = 0;
`endif

  logic clk, rst, start, abort, ready, done;
  logic [FC-1:0] errors;
  logic [FW-1:0] func_index, line_channel;
  logic parser_start, parser_ready, parser_error;
  logic eval_start, eval_ready, eval_y_valid;
  logic [XW-1:0] eval_x, x1, x2;
  logic [YW-1:0] eval_y, y1, y2;
  logic line_start, line_ready;
  logic [3:0] state_dbg;

  plot_sequencer #(.HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER),
                   .FUNC_COUNT(FC), .X_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready), .done(done),
    .errors(errors), .func_index(func_index),
    .parser_start(parser_start), .parser_ready(parser_ready), .parser_error(parser_error),
    .eval_start(eval_start), .eval_ready(eval_ready), .eval_x(eval_x),
    .eval_y(eval_y), .eval_y_valid(eval_y_valid),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .line_start(line_start), .line_ready(line_ready), .line_channel(line_channel),
    .state_dbg(state_dbg));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // stimulus tables
  bit          perr  [4];
  int          yoff  [4];
  logic [7:0]  inval [4];
  int parse_lat = 3, eval_lat = 2, line_lat = 4;
  bit model_on = 1'b0;

  // scoreboard
  logic [FW-1:0] parse_q[$];
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] seg_q[$];
  logic [XW-1:0] obs_x[$];
  logic [SW-1:0] obs_seg[$];
  int n_checks = 0, n_pass = 0;
  int done_cnt = 0, pulse_cnt = 0, first_kind = 0;
  bit done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [YW-1:0] y_of(input int f, input int x);
    return YW'(x + yoff[f]);
  endfunction

  function automatic logic [SW-1:0] seg(input int ch, input int ax, input int ay,
                                        input int bx, input int by);
    return {FW'(ch), XW'(ax), YW'(ay), XW'(bx), YW'(by)};
  endfunction

  function automatic logic [FC-1:0] exp_errors();
    logic [FC-1:0] e;
    for (int f = 0; f < FC; f++) e[f] = perr[f];
    return e;
  endfunction

  // Expected parse, evaluate and segment events for one whole run.
  task automatic build_expect();
    int x, px, py, y;
    bit pv, v, last;
    parse_q.delete(); exp_q.delete(); seg_q.delete();
    if (AXES == 1) begin
      seg_q.push_back(seg(FC, 0, VER/2, HOR-1, VER/2));
      seg_q.push_back(seg(FC, HOR/2, 0, HOR/2, VER-1));
    end
    for (int f = 0; f < FC; f++) begin
      parse_q.push_back(FW'(f));
      if (!perr[f]) begin
        pv = 1'b0; px = 0; py = 0; x = 0; last = 1'b0;
        while (!last) begin
          exp_q.push_back({FW'(f), XW'(x)});
          y = int'(y_of(f, x));
          v = !inval[f][x];
          if (pv && v) seg_q.push_back(seg(f, px, py, x, y));
          pv = v; px = x; py = y;
          if (x == HOR-1) last = 1'b1;
          else x = (x + STEP > HOR-1) ? HOR-1 : x + STEP;
        end
      end
    end
  endtask

  // responders
  initial begin
    parser_ready = 1'b1; parser_error = 1'b0;
    forever begin
      @(negedge clk);
      if (parser_start) begin
        parser_ready = 1'b0; parser_error = 1'b0;
        repeat (parse_lat) @(negedge clk);
        parser_error = perr[func_index];
        parser_ready = 1'b1;
      end
    end
  end

  initial begin
    eval_ready = 1'b1; eval_y = '0; eval_y_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (eval_start) begin
        eval_ready = 1'b0;
        repeat (eval_lat) @(negedge clk);
        eval_y       = y_of(func_index, eval_x);
        eval_y_valid = !inval[func_index][eval_x];
        eval_ready   = 1'b1;
      end
    end
  end

  initial begin
    logic [2*XW+2*YW-1:0] snap;
    line_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (line_start) begin
        snap = {x1, y1, x2, y2};
        line_ready = 1'b0;
        repeat (line_lat) begin
          @(negedge clk);
          if (model_on) check("line_hold", {x1, y1, x2, y2}, snap);
        end
        line_ready = 1'b1;
      end
    end
  end

  // compare process
  initial forever begin
    @(negedge clk);
    if (done_prev) check("ready_after_done", ready, 1);
    done_prev = done;
    pulse_cnt += int'(parser_start) + int'(eval_start) + int'(line_start);
    if (done) done_cnt++;
    if (model_on) begin
      if (parser_start) begin
        if (first_kind == 0) first_kind = 1;
        if (parse_q.size() == 0) check("parser_start_extra", 1, 0);
        else check("parse_func", func_index, parse_q.pop_front());
      end
      if (eval_start) begin
        obs_x.push_back(eval_x);
        if (exp_q.size() == 0) check("eval_start_extra", 1, 0);
        else check("eval_point", {func_index, eval_x}, exp_q.pop_front());
      end
      if (line_start) begin
        if (first_kind == 0) first_kind = 2;
        obs_seg.push_back({line_channel, x1, y1, x2, y2});
        if (seg_q.size() == 0) check("line_start_extra", 1, 0);
        else check("segment", {line_channel, x1, y1, x2, y2}, seg_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_plot(input bit extra_start);
    build_expect();
    obs_x.delete(); obs_seg.delete();
    done_cnt = 0; first_kind = 0; model_on = 1'b1;
    check("ready_before_start", ready, 1);
    pulse_start();
    if (extra_start) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("queues_drained", parse_q.size() + exp_q.size() + seg_q.size(), 0);
    check("errors", errors, exp_errors());
  endtask

  task automatic check_seg(input string name, input int idx, input logic [SW-1:0] exp);
    if (idx < obs_seg.size()) check(name, obs_seg[idx], exp);
    else begin
      n_checks++;
      $display("FAIL %s: segment %0d missing, expected %0h", name, idx, exp);
    end
  endtask

  task automatic reset_outputs_check(input string name);
    check({name, "_ready"}, ready, 1);
    check({name, "_outputs"}, {done, errors, func_index, parser_start, eval_start, eval_x,
                               x1, y1, x2, y2, line_start, line_channel}, 0);
  endtask

  initial begin
    int lit_x[4] = '{0, 3, 6, 7};
    int p0, base;
    base = 2 * AXES;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    for (int f = 0; f < 4; f++) begin perr[f] = 1'b0; yoff[f] = 0; inval[f] = 8'h00; end
    repeat (3) @(negedge clk);
    reset_outputs_check("reset");
    rst = 1'b0;

    // y=x all valid on f0, f1 fails parse
    perr[1] = 1'b1;
    run_plot(1'b0);
    check("t1_first_pulse", first_kind, (AXES == 1) ? 2 : 1);
    check("t1_eval_count", obs_x.size(), 4);
    for (int i = 0; i < 4 && i < obs_x.size(); i++) check("t1_eval_x", obs_x[i], lit_x[i]);
    check("t1_seg_count", obs_seg.size(), base + 3);
    check_seg("t1_seg0", base + 0, seg(0, 0, 0, 3, 3));
    check_seg("t1_seg1", base + 1, seg(0, 3, 3, 6, 6));
    check_seg("t1_seg2", base + 2, seg(0, 6, 6, 7, 7));
    if (AXES == 1) begin
      check_seg("t6_axis_h", 0, seg(FC, 0, 3, 7, 3));
      check_seg("t6_axis_v", 1, seg(FC, 4, 0, 4, 5));
    end

    // invalid point at x=3 breaks the curve
    inval[0] = 8'b0000_1000;
    run_plot(1'b0);
    check("t2_seg_count", obs_seg.size(), base + 1);
    check_seg("t2_seg0", base, seg(0, 6, 6, 7, 7));

    // f0 parse fails, f1 drawn with offset; a start while busy is ignored
    perr[0] = 1'b1; perr[1] = 1'b0; inval[0] = 8'h00;
    yoff[1] = 2; inval[1] = 8'b0000_0001;
    parse_lat = 1; eval_lat = 3; line_lat = 2;
    run_plot(1'b1);
    check("t3_eval_count", obs_x.size(), 4);
    check("t3_seg_count", obs_seg.size(), base + 2);
    check_seg("t3_seg0", base, seg(1, 3, 5, 6, 0));
    check_seg("t3_seg1", base + 1, seg(1, 6, 0, 7, 1));

    // start together with abort in IDLE does nothing
    model_on = 1'b0;
    p0 = pulse_cnt;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    check("start_abort_idle_ready", ready, 1);
    check("start_abort_idle_pulses", pulse_cnt, p0);

    // abort while the line drawer is busy
    yoff[1] = 0; inval[1] = 8'h00; line_lat = 8; done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 500 && !line_start; i++) @(negedge clk);
    if (!line_start) check("abort_line_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    p0 = pulse_cnt;
    @(negedge clk);
    abort = 1'b0;
    check("abort_drain_ready", ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_drain_ready", ready, 0);
    end
    @(negedge clk);
    check("abort_ready_after_line", ready, 1);
    repeat (10) @(negedge clk);
    check("abort_no_pulses", pulse_cnt, p0);
    check("abort_no_done", done_cnt, 0);
    check("abort_errors_kept", errors, (AXES == 1) ? 2'b00 : 2'b01);

    // reset during EVAL_WAIT, then a clean run
    perr[0] = 1'b0; line_lat = 3; eval_lat = 10;
    pulse_start();
    for (int i = 0; i < 500 && !eval_start; i++) @(negedge clk);
    if (!eval_start) check("reset_eval_timeout", 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_outputs_check("midrun_reset");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    eval_lat = 2; yoff[1] = 1; inval[0] = 8'b0100_0000;
    run_plot(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
